// File: rtl/bubble_sort_pkg.sv
// Shared constants for the bubble-sort controller and its datapath.
`timescale 1ns/1ps
package bubble_sort_pkg;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_IDX_W = 3;
    localparam int unsigned DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Control/status bundle between the bubble-sort controller and the element datapath.
`timescale 1ns/1ps
interface bubble_sort_ctrl_if
    import bubble_sort_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W
);
    logic             start;
    logic             a_gt_b;
    logic [IDX_W-1:0] idx;
    logic             swap_sel;
    logic             wr_en;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] pass_cnt;

    modport slave (
        input  start, a_gt_b,
        output idx, swap_sel, wr_en, busy, done, pass_cnt
    );

    modport master (
        output start, a_gt_b,
        input  idx, swap_sel, wr_en, busy, done, pass_cnt
    );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer: walks compare positions, strobes swaps, exits early on a clean pass.
`timescale 1ns/1ps
module bubble_sort_ctrl
    import bubble_sort_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned IDX_W = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    bubble_sort_ctrl_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_P = IDX_W'(N - 2);

    state_t           state, state_n;
    logic [IDX_W-1:0] j, j_n;
    logic [IDX_W-1:0] p, p_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [IDX_W-1:0] last_j;
    logic             gt_q, gt_n;
    logic             swapped, swapped_n;
    logic             sel_q, sel_n;
    logic             wr_q, wr_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             pass_end;
    logic             any_swap;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            j       <= '0;
            p       <= '0;
            gt_q    <= 1'b0;
            swapped <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            j       <= j_n;
            p       <= p_n;
            gt_q    <= gt_n;
            swapped <= swapped_n;
            idx_q   <= idx_n;
            sel_q   <= sel_n;
            wr_q    <= wr_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next state; outputs are derived from the next state so they line up with it
    always_comb begin
        state_n   = state;
        j_n       = j;
        p_n       = p;
        gt_n      = gt_q;
        swapped_n = swapped;
        last_j    = LAST_P - p;
        pass_end  = (j == last_j);
        any_swap  = swapped | gt_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n   = COMPARE;
                    j_n       = '0;
                    p_n       = '0;
                    swapped_n = 1'b0;
                end
            end
            COMPARE: begin
                gt_n    = bus.a_gt_b;
                state_n = WRITE;
            end
            WRITE: begin
                swapped_n = any_swap;
                if (!pass_end) begin
                    j_n     = j + 1'b1;
                    state_n = COMPARE;
                end else if ((p == LAST_P) || !any_swap) begin
                    state_n = DONE;
                end else begin
                    p_n       = p + 1'b1;
                    j_n       = '0;
                    swapped_n = 1'b0;
                    state_n   = COMPARE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        idx_n  = ((state_n == COMPARE) || (state_n == WRITE)) ? j_n : '0;
        sel_n  = (state_n == WRITE) && gt_n;
        wr_n   = (state_n == WRITE) && gt_n;
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign bus.idx      = idx_q;
    assign bus.swap_sel = sel_q;
    assign bus.wr_en    = wr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = p;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: table vectors, random arrays vs. an algorithmic model, reset and start corner cases.
`timescale 1ns/1ps
module tb_bubble_sort_ctrl;

    typedef struct {
        logic [63:0] vals;
        int          exp_wr;
        int          exp_busy;
        int          exp_pass;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] arr8 [8];
    vec_t       tbl [6];

    bubble_sort_ctrl_if #(.IDX_W(3)) b8 ();
    bubble_sort_ctrl_if #(.IDX_W(1)) b2 ();

    bubble_sort_ctrl #(.N(8), .IDX_W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    bubble_sort_ctrl #(.N(2), .IDX_W(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    always #5 clk = ~clk;

    // Bench-side datapath comparator
    always_comb b8.a_gt_b = (b8.idx < 3'd7) ? (arr8[b8.idx] > arr8[b8.idx + 3'd1]) : 1'b0;
    assign b2.a_gt_b = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack8();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = arr8[i];
        return r;
    endfunction

    // Algorithmic bubble sort with early exit
    task automatic model8(input logic [63:0] vals, output int swaps, output int compares,
                          output int passes, output logic [63:0] sorted);
        logic [7:0] a [8];
        logic [7:0] t;
        bit         sw;
        bit         stop;
        for (int i = 0; i < 8; i++) a[i] = vals[i*8 +: 8];
        swaps = 0; compares = 0; passes = 0; stop = 0;
        for (int p = 0; p <= 6; p++) begin
            if (!stop) begin
                sw = 0;
                passes = p;
                for (int j = 0; j <= 6 - p; j++) begin
                    compares++;
                    if (a[j] > a[j+1]) begin
                        t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                        swaps++;
                        sw = 1;
                    end
                end
                if (!sw) stop = 1;
            end
        end
        for (int i = 0; i < 8; i++) sorted[i*8 +: 8] = a[i];
    endtask

    task automatic dp8_write();
        logic [7:0] t;
        if (b8.wr_en && b8.swap_sel && (b8.idx < 3'd7)) begin
            t = arr8[b8.idx];
            arr8[b8.idx] = arr8[b8.idx + 3'd1];
            arr8[b8.idx + 3'd1] = t;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge after the sort
    task automatic run8(input logic [63:0] vals, input bit hold, output int wr_cnt, output int busy_cnt,
                        output int done_cnt, output int pass_at_done, output int viol,
                        output bit first_busy, output bit timed_out);
        bit seen;
        for (int i = 0; i < 8; i++) arr8[i] = vals[i*8 +: 8];
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; pass_at_done = -1; viol = 0;
        first_busy = 0; seen = 0; timed_out = 1;
        b8.start = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (!hold) b8.start = 1'b0;
            if (cyc == 0) first_busy = b8.busy;
            if (b8.busy) begin busy_cnt++; seen = 1; end
            if (b8.wr_en !== b8.swap_sel) viol++;
            if (b8.wr_en) begin
                wr_cnt++;
                if (b8.idx > 3'd6) viol++;
                dp8_write();
            end
            if (!b8.busy && ((b8.idx !== 3'd0) || b8.wr_en || b8.swap_sel)) viol++;
            if (b8.done) begin
                done_cnt++;
                pass_at_done = int'(b8.pass_cnt);
                if (!b8.busy) viol++;
            end
            if (seen && !b8.busy) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    initial begin
        int          wr, bz, dn, ps, vl, m_sw, m_cmp, m_ps, cnt;
        bit          fb, to, found;
        logic [63:0] vals, m_sorted;

        tbl[0] = '{64'h0706050403020100,  0, 15, 0};  // sorted
        tbl[1] = '{64'h0001020304050607, 28, 57, 6};  // reverse
        tbl[2] = '{64'h0705060403020100,  1, 27, 1};  // inversion at 5/6
        tbl[3] = '{64'h0706050403020001,  1, 27, 1};  // inversion at 0/1
        tbl[4] = '{64'h0007060504030201,  7, 57, 6};  // smallest element last
        tbl[5] = '{64'h5555555555555555,  0, 15, 0};  // all equal

        b8.start = 1'b0;
        b2.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(b8.busy), 64'd0);
        chk("rst_done", 64'(b8.done), 64'd0);
        chk("rst_wr_en", 64'(b8.wr_en), 64'd0);
        chk("rst_swap_sel", 64'(b8.swap_sel), 64'd0);
        chk("rst_idx", 64'(b8.idx), 64'd0);
        chk("rst_pass_cnt", 64'(b8.pass_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", 64'(b8.busy), 64'd0);

        for (int v = 0; v < 6; v++) begin
            model8(tbl[v].vals, m_sw, m_cmp, m_ps, m_sorted);
            run8(tbl[v].vals, 1'b0, wr, bz, dn, ps, vl, fb, to);
            chk($sformatf("tbl%0d_timeout", v), 64'(to), 64'd0);
            chk($sformatf("tbl%0d_wr_cnt", v), 64'(wr), 64'(tbl[v].exp_wr));
            chk($sformatf("tbl%0d_busy", v), 64'(bz), 64'(tbl[v].exp_busy));
            chk($sformatf("tbl%0d_done_cnt", v), 64'(dn), 64'd1);
            chk($sformatf("tbl%0d_pass", v), 64'(ps), 64'(tbl[v].exp_pass));
            chk($sformatf("tbl%0d_protocol", v), 64'(vl), 64'd0);
            chk($sformatf("tbl%0d_first_busy", v), 64'(fb), 64'd1);
            chk($sformatf("tbl%0d_sorted", v), pack8(), m_sorted);
            @(negedge clk);
        end

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) vals[i*8 +: 8] = 8'($urandom_range(0, 15));
            model8(vals, m_sw, m_cmp, m_ps, m_sorted);
            run8(vals, 1'b0, wr, bz, dn, ps, vl, fb, to);
            chk($sformatf("rnd%0d_wr_cnt", r), 64'(wr), 64'(m_sw));
            chk($sformatf("rnd%0d_busy", r), 64'(bz), 64'(2 * m_cmp + 1));
            chk($sformatf("rnd%0d_pass", r), 64'(ps), 64'(m_ps));
            chk($sformatf("rnd%0d_misc", r), {32'(dn), 30'(vl), fb, to}, {32'd1, 30'd0, 1'b1, 1'b0});
            chk($sformatf("rnd%0d_sorted", r), pack8(), m_sorted);
            @(negedge clk);
        end

        // start held high across two sorts
        run8(tbl[0].vals, 1'b1, wr, bz, dn, ps, vl, fb, to);
        chk("hold1_busy", 64'(bz), 64'd15);
        chk("hold1_done_cnt", 64'(dn), 64'd1);
        run8(tbl[0].vals, 1'b1, wr, bz, dn, ps, vl, fb, to);
        b8.start = 1'b0;
        chk("hold2_restart_after_one_idle", 64'(fb), 64'd1);
        chk("hold2_busy", 64'(bz), 64'd15);
        chk("hold2_timeout", 64'(to), 64'd0);
        @(negedge clk);
        chk("hold_release_idle", 64'(b8.busy), 64'd0);

        // Reset during a WRITE of pass 2
        for (int i = 0; i < 8; i++) arr8[i] = 8'(7 - i);
        b8.start = 1'b1;
        found = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            b8.start = 1'b0;
            if (b8.wr_en && (b8.pass_cnt == 3'd2)) begin
                found = 1;
                break;
            end
            dp8_write();
        end
        chk("midrst_reached_pass2_write", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(b8.busy), 64'd0);
        chk("midrst_wr_en", 64'(b8.wr_en), 64'd0);
        chk("midrst_swap_sel", 64'(b8.swap_sel), 64'd0);
        chk("midrst_idx_pass", {b8.idx, b8.pass_cnt, b8.done}, 7'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (b8.busy || b8.wr_en) cnt++;
        end
        chk("postrst_stays_idle", 64'(cnt), 64'd0);
        run8(tbl[1].vals, 1'b0, wr, bz, dn, ps, vl, fb, to);
        chk("postrst_resort_wr", 64'(wr), 64'd28);
        chk("postrst_resort_busy", 64'(bz), 64'd57);
        @(negedge clk);

        // N=2 instance with a_gt_b tied high
        b2.start = 1'b1;
        wr = 0; bz = 0; dn = 0; ps = -1; vl = 0; found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            b2.start = 1'b0;
            if (b2.busy) begin bz++; found = 1; end
            if (b2.wr_en) begin
                wr++;
                if ((b2.idx !== 1'b0) || !b2.swap_sel) vl++;
            end
            if (b2.done) begin dn++; ps = int'(b2.pass_cnt); end
            if (found && !b2.busy) break;
        end
        chk("n2_wr_cnt", 64'(wr), 64'd1);
        chk("n2_busy", 64'(bz), 64'd3);
        chk("n2_done_cnt", 64'(dn), 64'd1);
        chk("n2_pass", 64'(ps), 64'd0);
        chk("n2_protocol", 64'(vl), 64'd0);
        chk("n2_returns_idle", 64'(b2.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bubble_sort_ctrl.md
BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of elements in the sorted array (N >= 2).
REQ-002 The block SHALL have parameter IDX_W, default 3, meaning the index width, equal to ceil(log2(N)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a level sampled in IDLE that begins a sort.
REQ-006 The block SHALL have port a_gt_b, input, 1 bit: the datapath comparator result, elem[idx] > elem[idx+1].
REQ-007 The block SHALL have port idx, output, IDX_W bits: the compare position j presented to the datapath.
REQ-008 The block SHALL have port swap_sel, output, 1 bit: drives the sel input of the datapath swap 2:1 muxes (1 = cross-load).
REQ-009 The block SHALL have port wr_en, output, 1 bit: the write strobe for elem[idx] and elem[idx+1].
REQ-010 The block SHALL have port busy, output, 1 bit: high from the first cycle after accepted start through the DONE cycle, inclusive.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking sort completion.
REQ-012 The block SHALL have port pass_cnt, output, IDX_W bits: the current pass number p.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, COMPARE, WRITE, DONE.
REQ-014 IDLE: when start=1, the FSM SHALL go to COMPARE with p=0, j=0, swapped=0; start SHALL be ignored in all other states.
REQ-015 COMPARE: the block SHALL drive idx=j for one cycle and register a_gt_b into gt_q at the end of the cycle; then go to WRITE.
REQ-016 WRITE: idx SHALL hold j, swap_sel=gt_q, wr_en=gt_q; swapped SHALL be set if gt_q=1.
REQ-017 WRITE next-state, if j < N-2-p: j <= j+1, go to COMPARE.
REQ-018 WRITE next-state, if j = N-2-p (end of pass) and either p = N-2 or no swap occurred in this pass (including the current WRITE): go to DONE.
REQ-019 WRITE next-state, at end of pass otherwise: p <= p+1, j <= 0, swapped <= 0, go to COMPARE.
REQ-020 DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE; a start asserted during DONE SHALL be ignored.
REQ-021 Each compare SHALL take exactly 2 cycles; a pass p SHALL issue N-1-p compares.
REQ-022 Outside WRITE, wr_en and swap_sel SHALL be 0; outside COMPARE and WRITE, idx SHALL be 0.
REQ-023 j and p arithmetic SHALL be unsigned IDX_W-bit and SHALL never wrap; the loop bounds above guarantee idx+1 <= N-1.
REQ-024 All outputs SHALL be driven from registered state (Moore); there SHALL be no combinational path from start or a_gt_b to any output.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, asynchronously, force the state to IDLE and set idx, pass_cnt, j, gt_q, swapped, swap_sel, wr_en, busy and done to 0.
REQ-026 A reset asserted mid-sort SHALL abandon the sort with no further wr_en; after deassertion the block SHALL wait in IDLE for a new start.

Structure
REQ-027 The state encoding constants (IDLE, COMPARE, WRITE, DONE) SHALL live in a shared package bubble_sort_pkg, together with the default N and data width used by the datapath.
REQ-028 The block SHALL be a single module with no sub-modules; the 2:1 swap muxes, the comparator and the element registers SHALL stay in the datapath.

Verification
REQ-029 Sorted input (N=8, a_gt_b=0 always), start pulse -> 7 compares, 0 wr_en pulses, busy high for 15 cycles, done one cycle, pass_cnt=0 at done.
REQ-030 Reverse-sorted input (bench model swaps the array on wr_en) -> 28 wr_en pulses, each with swap_sel=1; busy for 57 cycles; pass_cnt=6 at done.
REQ-031 A single inversion at positions 5/6 -> one swap in pass 0, early exit after pass 1; busy = 2*(7+6)+1 = 27 cycles.
REQ-032 rst_n pulled low during WRITE of pass 2 -> all outputs 0 within the same cycle, state IDLE, no wr_en until a new start.
REQ-033 start held high continuously -> start is ignored while busy; a new sort begins on the first IDLE cycle after DONE, so busy is low for exactly one cycle between sorts.
REQ-034 Generic check with N=2 (IDX_W=1) and a_gt_b=1 -> exactly one compare with one wr_en pulse, busy for 3 cycles, then done.
